// File: rtl/exc_ctrl.sv
// Exception controller: forwards CP0 status/cause/epc from WB, prioritises
// MEM-stage exceptions and interrupts, and drives a one-cycle flush with the
// fetch redirect target. An IDLE/FLUSH FSM prevents a held instruction from
// being reported twice.
// Ports: clk, rst (sync, active-high); stall_i, excepttype_i, pc_i,
//   is_in_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i,
//   wb_cp0_waddr_i, wb_cp0_data_i in; except_type_o, pc_o,
//   is_in_delayslot_o, flush_o, new_pc_o, epc_o out.
module exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] except_type_o,
  output logic [31:0] pc_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] epc_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [4:0]  REG_STATUS = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;
  // Cause bits software can write: IP1..IP0, IV, WP
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [31:0] VEC_BOOT = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM = 32'h8000_0180;

  state_e      state_q;
  logic [31:0] exc_cnt_q;

  logic [31:0] status_fwd;
  logic [31:0] cause_fwd;
  logic [31:0] epc_fwd;
  logic        int_pend;
  logic        live;
  logic [31:0] exc_d;
  logic        unused_ok;

  always_comb begin
    status_fwd = cp0_status_i;
    cause_fwd  = cp0_cause_i;
    epc_fwd    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == REG_STATUS)
        status_fwd = wb_cp0_data_i;
      if (wb_cp0_waddr_i == REG_CAUSE)
        cause_fwd = (cp0_cause_i & ~CAUSE_WMASK)
                  | (wb_cp0_data_i & CAUSE_WMASK);
      if (wb_cp0_waddr_i == REG_EPC)
        epc_fwd = wb_cp0_data_i;
    end
  end

  assign int_pend = (|(cause_fwd[15:8] & status_fwd[15:8]))
                  && !status_fwd[1] && status_fwd[0];

  // FLUSH blocks re-reporting the instruction that just trapped
  assign live = !rst && (pc_i != 32'h0) && !stall_i
              && (state_q == IDLE);

  always_comb begin
    exc_d = EXC_NONE;
    if (live) begin
      priority case (1'b1)
        int_pend:         exc_d = EXC_INT;
        excepttype_i[8]:  exc_d = EXC_SYS;
        excepttype_i[9]:  exc_d = EXC_RI;
        excepttype_i[10]: exc_d = EXC_TRAP;
        excepttype_i[11]: exc_d = EXC_OV;
        excepttype_i[12]: exc_d = EXC_ERET;
        default:          exc_d = EXC_NONE;
      endcase
    end
  end

  always_comb begin
    except_type_o     = exc_d;
    flush_o           = (exc_d != EXC_NONE);
    new_pc_o          = 32'h0;
    epc_o             = rst ? 32'h0 : epc_fwd;
    pc_o              = rst ? 32'h0 : pc_i;
    is_in_delayslot_o = rst ? 1'b0 : is_in_delayslot_i;
    if (flush_o) begin
      if (exc_d == EXC_ERET)
        new_pc_o = epc_fwd;
      else
        new_pc_o = status_fwd[22] ? VEC_BOOT : VEC_NORM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exc_cnt_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= flush_o ? FLUSH : IDLE;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (flush_o)
        exc_cnt_q <= exc_cnt_q + 32'h1;
    end
  end

  assign unused_ok = ^{excepttype_i[31:13], excepttype_i[7:0],
                       cause_fwd[31:16], cause_fwd[7:0],
                       status_fwd[31:23], status_fwd[21:16],
                       status_fwd[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the exception rules.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] except_type_o;
  logic [31:0] pc_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] epc_o;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .excepttype_i      (excepttype_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .cp0_status_i      (cp0_status_i),
    .cp0_cause_i       (cp0_cause_i),
    .cp0_epc_i         (cp0_epc_i),
    .wb_cp0_we_i       (wb_cp0_we_i),
    .wb_cp0_waddr_i    (wb_cp0_waddr_i),
    .wb_cp0_data_i     (wb_cp0_data_i),
    .except_type_o     (except_type_o),
    .pc_o              (pc_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .epc_o             (epc_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: did the previous cycle take an exception?
  bit          m_took_prev = 1'b0;
  int unsigned m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall_i = 1'b0; excepttype_i = 32'h0;
    pc_i = 32'h0; is_in_delayslot_i = 1'b0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
  endtask

  // Check outputs for the current inputs, then advance one clock.
  task automatic step();
    logic [31:0] st, ca, ep, code, npc;
    bit intr, live;
    #2;
    st = cp0_status_i;
    ca = cp0_cause_i;
    ep = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
      ca[9:8] = wb_cp0_data_i[9:8];
      ca[22]  = wb_cp0_data_i[22];
      ca[23]  = wb_cp0_data_i[23];
    end
    intr = ((ca[15:8] & st[15:8]) != 8'h0) && !st[1] && st[0];
    live = !rst && pc_i != 0 && !stall_i && !m_took_prev;
    code = 32'h0;
    if (live) begin
      if (intr) code = 32'h1;
      else if (excepttype_i[8])  code = 32'h8;
      else if (excepttype_i[9])  code = 32'ha;
      else if (excepttype_i[10]) code = 32'hd;
      else if (excepttype_i[11]) code = 32'hc;
      else if (excepttype_i[12]) code = 32'he;
    end
    if (code == 0) npc = 32'h0;
    else if (code == 32'he) npc = ep;
    else npc = st[22] ? 32'hBFC00380 : 32'h80000180;
    chk("except_type", except_type_o, code);
    chk("flush", {31'h0, flush_o}, {31'h0, code != 0});
    chk("new_pc", new_pc_o, npc);
    chk("epc", epc_o, rst ? 32'h0 : ep);
    chk("pc", pc_o, rst ? 32'h0 : pc_i);
    chk("delayslot", {31'h0, is_in_delayslot_o},
        {31'h0, rst ? 1'b0 : is_in_delayslot_i});
    if (rst) begin
      m_took_prev = 1'b0;
      m_cnt = 0;
    end else begin
      m_took_prev = (code != 0);
      if (code != 0) m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("exc_cnt", dut.exc_cnt_q, m_cnt);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    pc_i = 32'h80000100;
    excepttype_i = 32'h100;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    step();

    // syscall, BEV=1
    pc_i = 32'h80000100; excepttype_i = 32'h100;
    cp0_status_i = 32'h10400000;
    #1;
    chk("sys_code", except_type_o, 32'h8);
    chk("sys_vec", new_pc_o, 32'hBFC00380);
    step();
    chk("sys_after", {31'h0, flush_o}, 32'h0);
    excepttype_i = 32'h0;
    step();

    // eret with forwarded EPC
    excepttype_i = 32'h1000; cp0_epc_i = 32'h1000;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h2000;
    #1;
    chk("eret_code", except_type_o, 32'he);
    chk("eret_pc", new_pc_o, 32'h2000);
    step();
    idle_inputs();
    step();

    // interrupt beats overflow, then EXL masks it
    pc_i = 32'h80000200; excepttype_i = 32'h800;
    cp0_cause_i = 32'h400; cp0_status_i = 32'h401;
    #1;
    chk("int_prio", except_type_o, 32'h1);
    step();
    step();
    cp0_status_i = 32'h403;
    #1;
    chk("exl_ov", except_type_o, 32'hc);
    step();
    idle_inputs();
    step();

    // stalled syscall reported once on release
    pc_i = 32'h80000300; excepttype_i = 32'h100; stall_i = 1'b1;
    repeat (3) step();
    stall_i = 1'b0;
    step();
    step();
    idle_inputs();

    // bubble, then back-to-back hold
    excepttype_i = 32'h200;
    step();
    pc_i = 32'h80000400;
    step();
    step();
    idle_inputs();

    // reset while in FLUSH
    pc_i = 32'h80000500; excepttype_i = 32'h400;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    excepttype_i = 32'h0;
    step();
    idle_inputs();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      pc_i = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      excepttype_i = $urandom & 32'hFFFF_E0FF;
      if ($urandom_range(0, 1) == 1)
        excepttype_i[12:8] = 5'b1 << $urandom_range(0, 4);
      else if ($urandom_range(0, 1) == 1)
        excepttype_i[12:8] = 5'($urandom);
      is_in_delayslot_i = 1'($urandom);
      cp0_status_i = $urandom;
      cp0_status_i[1] = ($urandom_range(0, 2) == 0);
      cp0_cause_i = $urandom;
      if ($urandom_range(0, 1) == 1) cp0_cause_i[15:8] = 8'h0;
      cp0_epc_i = $urandom;
      wb_cp0_we_i = 1'($urandom);
      wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      wb_cp0_data_i = $urandom;
      step();
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
